// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared state encoding and op codes for the memory path controller
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    DATA  = 3'd2,
    MEM   = 3'd3,
    LATCH = 3'd4,
    DRIVE = 3'd5,
    CLEAN = 3'd6
  } mem_state_e;

  localparam logic OP_READ  = 1'b1;
  localparam logic OP_WRITE = 1'b0;

endpackage

// File: rtl/mem_timeout_cnt.sv
// rtl/mem_timeout_cnt.sv - wait-cycle counter that flags the last allowed cycle of an MFC wait
module mem_timeout_cnt #(
  parameter int TIMEOUT = 15,
  parameter int TW      = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) count <= '0;
    else if (enable)    count <= count + 1'b1;
  end

  // Fires in the cycle whose miss would make the count reach TIMEOUT.
  assign expired = enable && (count == LAST);

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - arbiter and strobe sequencer for the shared bus/MAR/MDR/memory path
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int TW      = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req,
  input  logic ex_req,
  input  logic ex_rw,
  input  logic mfc,
  output logic if_gnt,
  output logic ex_gnt,
  output logic if_addr_out_en,
  output logic ex_addr_out_en,
  output logic ex_data_out_en,
  output logic mar_load,
  output logic mdr_write_en,
  output logic mdr_read_en,
  output logic mdr_out_en,
  output logic mem_en,
  output logic r_w,
  output logic if_done,
  output logic ex_done,
  output logic err
);

  localparam int O_IF_GNT = 13, O_EX_GNT = 12, O_IF_ADDR = 11, O_EX_ADDR = 10, O_EX_DATA = 9;
  localparam int O_MAR = 8, O_MDR_W = 7, O_MDR_R = 6, O_MDR_OUT = 5, O_MEM = 4, O_RW = 3;
  localparam int O_IF_DONE = 2, O_EX_DONE = 1, O_ERR = 0;

  mem_state_e  state, stateNext;
  logic        ownerEx, ownerExNext;
  logic        op, opNext;
  logic        lastEx, lastExNext;
  logic        errFlag, errFlagNext;
  logic        expired;
  logic        grantEx;
  logic [13:0] outNext, outQ;

  mem_timeout_cnt #(.TIMEOUT(TIMEOUT), .TW(TW)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (state != MEM),
    .enable  ((state == MEM) && !mfc),
    .expired (expired)
  );

  always_comb begin
    stateNext   = state;
    ownerExNext = ownerEx;
    opNext      = op;
    lastExNext  = lastEx;
    errFlagNext = errFlag;
    grantEx     = 1'b0;
    case (state)
      IDLE: if (if_req || ex_req) begin
        // On contention the side that did not win last time gets the path.
        grantEx     = ex_req && (!if_req || !lastEx);
        ownerExNext = grantEx;
        lastExNext  = grantEx;
        opNext      = grantEx ? ex_rw : OP_READ;
        stateNext   = ADDR;
      end
      ADDR:  stateNext = (op == OP_READ) ? MEM : DATA;
      DATA:  stateNext = MEM;
      MEM: begin
        if (mfc) begin
          stateNext = (op == OP_READ) ? LATCH : CLEAN;
        end else if (expired) begin
          errFlagNext = 1'b1;
          stateNext   = CLEAN;
        end
      end
      LATCH: stateNext = DRIVE;
      DRIVE: stateNext = CLEAN;
      CLEAN: begin
        errFlagNext = 1'b0;
        stateNext   = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered strobes line up with the state.
  always_comb begin
    outNext = '0;
    if (stateNext != IDLE) begin
      outNext[O_IF_GNT] = !ownerExNext;
      outNext[O_EX_GNT] = ownerExNext;
    end
    case (stateNext)
      ADDR: begin
        outNext[O_IF_ADDR] = !ownerExNext;
        outNext[O_EX_ADDR] = ownerExNext;
        outNext[O_MAR]     = 1'b1;
      end
      DATA: begin
        outNext[O_EX_DATA] = 1'b1;
        outNext[O_MDR_W]   = 1'b1;
      end
      MEM: begin
        outNext[O_MEM] = 1'b1;
        outNext[O_RW]  = opNext;
      end
      LATCH: outNext[O_MDR_R] = 1'b1;
      DRIVE: begin
        outNext[O_MDR_OUT] = 1'b1;
        outNext[O_IF_DONE] = !ownerExNext;
        outNext[O_EX_DONE] = ownerExNext;
      end
      CLEAN: begin
        if (opNext == OP_WRITE || errFlagNext) begin
          outNext[O_IF_DONE] = !ownerExNext;
          outNext[O_EX_DONE] = ownerExNext;
        end
        outNext[O_ERR] = errFlagNext;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ownerEx <= 1'b0;
      op      <= OP_READ;
      lastEx  <= 1'b0;
      errFlag <= 1'b0;
      outQ    <= '0;
    end else begin
      state   <= stateNext;
      ownerEx <= ownerExNext;
      op      <= opNext;
      lastEx  <= lastExNext;
      errFlag <= errFlagNext;
      outQ    <= outNext;
    end
  end

  assign {if_gnt, ex_gnt, if_addr_out_en, ex_addr_out_en, ex_data_out_en, mar_load,
          mdr_write_en, mdr_read_en, mdr_out_en, mem_en, r_w, if_done, ex_done, err} = outQ;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - randomized bench checking mem_access_ctrl against a transaction-level model
module tb_mem_access_ctrl;

  localparam int TIMEOUT = 15;

  localparam int B_MEM = 4, B_IFDONE = 2, B_EXDONE = 1;
  localparam logic [13:0] M_IFG = 14'd1 << 13, M_EXG = 14'd1 << 12, M_IFA = 14'd1 << 11;
  localparam logic [13:0] M_EXA = 14'd1 << 10, M_EXD = 14'd1 << 9, M_MAR = 14'd1 << 8;
  localparam logic [13:0] M_MDRW = 14'd1 << 7, M_MDRR = 14'd1 << 6, M_MDRO = 14'd1 << 5;
  localparam logic [13:0] M_MEM = 14'd1 << 4, M_RW = 14'd1 << 3, M_IFDONE = 14'd1 << 2;
  localparam logic [13:0] M_EXDONE = 14'd1 << 1, M_ERR = 14'd1;

  logic clk = 1'b0;
  logic reset, if_req, ex_req, ex_rw, mfc;
  logic if_gnt, ex_gnt, if_addr_out_en, ex_addr_out_en, ex_data_out_en, mar_load;
  logic mdr_write_en, mdr_read_en, mdr_out_en, mem_en, r_w, if_done, ex_done, err;

  typedef struct packed {
    logic [13:0] vec;
    logic        mfcHere;
  } step_t;

  step_t q[$];
  int    nChecks = 0, nPass = 0;
  bit    lastEx, ifPend, exPend, rstPrev, armReset;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT(TIMEOUT), .TW(8)) dut (
    .clk(clk), .reset(reset), .if_req(if_req), .ex_req(ex_req), .ex_rw(ex_rw), .mfc(mfc),
    .if_gnt(if_gnt), .ex_gnt(ex_gnt), .if_addr_out_en(if_addr_out_en),
    .ex_addr_out_en(ex_addr_out_en), .ex_data_out_en(ex_data_out_en), .mar_load(mar_load),
    .mdr_write_en(mdr_write_en), .mdr_read_en(mdr_read_en), .mdr_out_en(mdr_out_en),
    .mem_en(mem_en), .r_w(r_w), .if_done(if_done), .ex_done(ex_done), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [13:0] obsVec();
    return {if_gnt, ex_gnt, if_addr_out_en, ex_addr_out_en, ex_data_out_en, mar_load,
            mdr_write_en, mdr_read_en, mdr_out_en, mem_en, r_w, if_done, ex_done, err};
  endfunction

  task automatic push(input logic [13:0] v, input logic m);
    q.push_back({v, m});
  endtask

  // Expected per-cycle output trace for one whole access; dly = MEM cycles of mfc=0 before mfc.
  task automatic buildTxn(input bit isEx, input bit rd, input int dly);
    logic [13:0] g, dn;
    bit to;
    int nMem;
    g    = isEx ? M_EXG : M_IFG;
    dn   = isEx ? M_EXDONE : M_IFDONE;
    to   = (dly >= TIMEOUT);
    nMem = to ? TIMEOUT : dly + 1;
    push(g | (isEx ? M_EXA : M_IFA) | M_MAR, 1'b0);
    if (!rd) push(g | M_EXD | M_MDRW, 1'b0);
    for (int i = 0; i < nMem; i++) push(g | M_MEM | (rd ? M_RW : 14'd0), (i == nMem - 1) && !to);
    if (rd && !to) begin
      push(g | M_MDRR, 1'b0);
      push(g | M_MDRO | dn, 1'b0);
    end
    push(g | ((!rd || to) ? dn : 14'd0) | (to ? M_ERR : 14'd0), 1'b0);
  endtask

  task automatic stepCycle(input int ifOdds, input int exOdds, input int toOdds);
    step_t cur;
    bit idle, doneIf, doneEx, gEx, rd;
    int dly;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      cur  = q.pop_front();
      idle = 1'b0;
    end else begin
      cur  = '0;
      idle = 1'b1;
    end
    chk(rstPrev ? "resetState" : "cycle", 32'(obsVec()), 32'(cur.vec));
    chk("busExcl", 32'($countones({if_addr_out_en, ex_addr_out_en, ex_data_out_en, mdr_out_en}) <= 1), 32'd1);
    chk("gntExcl", 32'(if_gnt & ex_gnt), 32'd0);
    rstPrev = 1'b0;
    reset   = 1'b0;
    doneIf  = cur.vec[B_IFDONE];
    doneEx  = cur.vec[B_EXDONE];
    if (doneIf) begin if_req = 1'b0; ifPend = 1'b0; end
    if (doneEx) begin ex_req = 1'b0; exPend = 1'b0; end
    if (!ifPend && !doneIf && ifOdds > 0 && $urandom_range(ifOdds - 1) == 0) begin
      if_req = 1'b1; ifPend = 1'b1;
    end
    if (!exPend && !doneEx && exOdds > 0 && $urandom_range(exOdds - 1) == 0) begin
      ex_req = 1'b1; exPend = 1'b1;
    end
    ex_rw = 1'($urandom_range(1));
    mfc   = cur.vec[B_MEM] ? cur.mfcHere : 1'($urandom_range(1));
    if (armReset && cur.vec[B_MEM]) begin
      reset = 1'b1; rstPrev = 1'b1; armReset = 1'b0; q.delete();
      if_req = 1'b0; ex_req = 1'b0; ifPend = 1'b0; exPend = 1'b0; lastEx = 1'b0;
    end else if (idle && (if_req || ex_req)) begin
      gEx    = ex_req && (!if_req || !lastEx);
      lastEx = gEx;
      rd     = gEx ? ex_rw : 1'b1;
      dly    = (toOdds > 0 && $urandom_range(toOdds - 1) == 0) ?
               int'($urandom_range(TIMEOUT + 2, TIMEOUT - 1)) : int'($urandom_range(3));
      buildTxn(gEx, rd, dly);
    end
  endtask

  task automatic runPhase(input int n, input int ifOdds, input int exOdds, input int toOdds);
    for (int c = 0; c < n; c++) stepCycle(ifOdds, exOdds, toOdds);
  endtask

  initial begin
    reset = 1'b1; if_req = 1'b0; ex_req = 1'b0; ex_rw = 1'b0; mfc = 1'b0;
    lastEx = 1'b0; ifPend = 1'b0; exPend = 1'b0; rstPrev = 1'b1; armReset = 1'b0;
    runPhase(300, 3, 0, 0);
    runPhase(300, 0, 3, 0);
    runPhase(400, 1, 1, 0);
    armReset = 1'b1;
    runPhase(200, 2, 2, 0);
    chk("resetFired", 32'(armReset), 32'd0);
    runPhase(2000, 1, 1, 3);
    runPhase(8000, 4, 4, 6);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
